cache_fill_arbiter: RTL
=======================

# cache_fill_arbiter

Sequences the shared multi-cycle main memory between the instruction-side and data-side cache controllers of the WISC pipeline. Both controllers raise a level request on a miss, as does the data side on a write-through store. This block grants one requester at a time. For a read miss it fetches the full 8-word block as a pipelined burst and streams the words back with write strobes. It sits between the two cache controllers and the single `memory4c`-style backing memory, replacing the direct `imem`/`data_mem` hookups.

## Interface
Parameters:
- AWIDTH, 16: address width in bits (byte addresses).
- DWIDTH, 16: data word width in bits.
- MEM_LAT, 4: cycles from address issue to `mem_data_valid` for that address; legal range 1-7.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- i_req  in  1  instruction-cache miss fill request; level, held until `i_done`.
- i_addr  in  AWIDTH  address of the missing instruction word.
- d_req  in  1  data-cache miss fill request; level, held until `d_done`.
- d_addr  in  AWIDTH  address of the missing data word.
- d_wr_req  in  1  write-through store request; level, held until `d_wr_done`.
- d_wr_addr  in  AWIDTH  store address.
- d_wr_data  in  DWIDTH  store data.
- mem_data_out  in  DWIDTH  read data returned by memory.
- mem_data_valid  in  1  `mem_data_out` is valid this cycle.
- mem_enable  out  1  memory access issued this cycle.
- mem_wr  out  1  issued access is a write.
- mem_addr  out  AWIDTH  issued address.
- mem_data_in  out  DWIDTH  write data.
- fill_data  out  DWIDTH  returned block word; combinational pass-through of `mem_data_out`.
- fill_word  out  3  index of `fill_data` within the block.
- fill_we_i  out  1  write `fill_data` into the I-cache data array.
- fill_we_d  out  1  write `fill_data` into the D-cache data array.
- i_done  out  1  one-cycle pulse: I fill complete.
- d_done  out  1  one-cycle pulse: D fill complete.
- d_wr_done  out  1  one-cycle pulse: store written.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, WRITE, FILL, DONE. Reset value: IDLE, with every output 0 and all counters and latches cleared.
- Arbitration happens in IDLE only:
  - `d_wr_req` always wins.
  - Otherwise, a single fill request is granted.
  - If both `d_req` and `i_req` are asserted, the side not served by the previous fill wins (`last_fill` flop, reset = I, so D wins first).
- On grant, the requester address is latched: block base = addr & 16'hFFF0, word bits = addr[3:1] (unused, since the whole block is filled). The grantee ID (I/D) is latched. The inputs are not re-sampled until the next IDLE.
- WRITE state, one cycle:
  - Outputs: `mem_enable`=1, `mem_wr`=1, `mem_addr`=`d_wr_addr` latched, `mem_data_in`=`d_wr_data` latched.
  - Next state: DONE with `d_wr_done`.
- FILL state:
  - A 3-bit issue counter drives `mem_addr` = base + {issue_cnt,1'b0}.
  - `mem_enable`=1 for exactly 8 consecutive cycles; `mem_wr`=0.
  - A separate 3-bit return counter advances on each `mem_data_valid`.
  - On each valid: `fill_word`=ret_cnt, and `fill_we_i` or `fill_we_d` (per the latched grantee) =1.
  - After the 8th valid, go to DONE.
- DONE state, one cycle:
  - Pulse the matching done signal.
  - Update `last_fill` (fill grants only).
  - Return to IDLE.
- Requesters must deassert the request in the cycle after their done pulse. Because of this, IDLE re-arbitrates one cycle after DONE without re-granting a completed request.
- `mem_data_valid` outside FILL is ignored: no strobes, no counter change.
- Counters wrap 7->0; word addresses never cross the 16-byte block.
- `mem_data_in` = 0 whenever not in WRITE. `fill_word` = 0 when no strobe is asserted.

## Timing
- Store: request seen in IDLE at cycle T.
  - WRITE at T+1.
  - `d_wr_done` at T+2.
  - IDLE at T+3.
- Fill: request seen in IDLE at T.
  - Word k issued at T+1+k (k=0..7).
  - Word k data with strobe at T+1+k+MEM_LAT.
  - DONE pulse at T+9+MEM_LAT (T+13 for MEM_LAT=4).
  - IDLE at T+10+MEM_LAT.
- Issue and return overlap; no bubble between issued addresses.
- Simultaneous requests in IDLE: resolved in the same cycle by the priority above. Losers are held, not dropped.
- Reset deasserted-low mid-burst: next cycle is IDLE with all outputs 0. Late `mem_data_valid` from the aborted burst produces no strobe. No done pulse is issued for the aborted transaction.

## Test plan
- Reset: hold rst=0 for 2 cycles while `i_req`=1 and `mem_data_valid`=1. Required: all outputs 0 and `busy`=0.
- I fill: `i_addr`=16'h0126 at T, with memory returning addr as data after MEM_LAT=4. Required:
  - `mem_addr` = 0120,0122,…,012E at T+1..T+8.
  - `fill_we_i` at T+5..T+12 with `fill_word` 0..7 and `fill_data` 0120..012E.
  - `i_done` at T+13.
- Store vs fill: `d_wr_req` (addr 16'h4002, data 16'hBEEF) and `d_req` asserted together. Required:
  - `mem_wr`=1, `mem_addr`=4002, `mem_data_in`=BEEF at T+1.
  - `d_wr_done` at T+2.
  - D fill issue begins at T+4.
- Alternation: `i_req` and `d_req` held continuously. Required: grant order D, I, D; each done pulse corresponds to the matching fill strobes.
- Spurious valid: `mem_data_valid` pulsed in IDLE and in WRITE. Required: no `fill_we_*`, and the return counter stays 0, so the next fill starts at `fill_word`=0.
- Reset mid-fill: drive rst=0 at cycle T+6 of a D fill. Required: IDLE at T+7, no `d_done`, later valids ignored, and a new `d_req` completes normally.

Source files
------------

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single multi-cycle memory between I-cache fills, D-cache fills
// and write-through stores; read misses become an 8-word pipelined burst.
module cache_fill_arbiter #(
  parameter int AWIDTH  = 16,
  parameter int DWIDTH  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic              d_req,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic              d_wr_req,
  input  logic [AWIDTH-1:0] d_wr_addr,
  input  logic [DWIDTH-1:0] d_wr_data,
  input  logic [DWIDTH-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data_in,
  output logic [DWIDTH-1:0] fill_data,
  output logic [2:0]        fill_word,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic              i_done,
  output logic              d_done,
  output logic              d_wr_done,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_DONE} state_t;

  localparam logic [AWIDTH-1:0] BLK_MASK = {{(AWIDTH-4){1'b1}}, 4'b0000};
  localparam logic [2:0]        LAT      = 3'(MEM_LAT);

  state_t              r_state, w_next;
  logic [AWIDTH-1:0]   r_base, r_wr_addr;
  logic [DWIDTH-1:0]   r_wr_data;
  logic                r_is_wr, r_grant_d, r_last_fill, r_issuing;
  logic [2:0]          r_issue_cnt, r_ret_cnt, r_lat_cnt;
  logic                w_fill_req, w_pick_d, w_ret_open, w_ret_fire, w_ret_last;

  assign w_fill_req = i_req | d_req;
  // r_last_fill: 0 = I was served last, so D wins a tie.
  assign w_pick_d   = d_req & (~i_req | ~r_last_fill);
  // Nothing this burst issued can return before MEM_LAT cycles into FILL, so
  // earlier valids are stale leftovers from an aborted burst.
  assign w_ret_open = (r_lat_cnt == LAT);
  assign w_ret_fire = (r_state == S_FILL) & w_ret_open & mem_data_valid;
  assign w_ret_last = w_ret_fire & (r_ret_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (d_wr_req)        w_next = S_WRITE;
               else if (w_fill_req) w_next = S_FILL;
      S_WRITE: w_next = S_DONE;
      S_FILL:  if (w_ret_last)      w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_base      <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_is_wr     <= 1'b0;
      r_grant_d   <= 1'b0;
      r_last_fill <= 1'b0;
      r_issuing   <= 1'b0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_lat_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (d_wr_req) begin
            r_is_wr   <= 1'b1;
            r_wr_addr <= d_wr_addr;
            r_wr_data <= d_wr_data;
          end else if (w_fill_req) begin
            r_is_wr     <= 1'b0;
            r_grant_d   <= w_pick_d;
            r_base      <= (w_pick_d ? d_addr : i_addr) & BLK_MASK;
            r_issuing   <= 1'b1;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_lat_cnt   <= '0;
          end
        end
        S_FILL: begin
          if (r_issuing) begin
            r_issue_cnt <= r_issue_cnt + 3'd1;
            if (r_issue_cnt == 3'd7) r_issuing <= 1'b0;
          end
          if (!w_ret_open) r_lat_cnt <= r_lat_cnt + 3'd1;
          if (w_ret_fire)  r_ret_cnt <= r_ret_cnt + 3'd1;
        end
        S_DONE: if (!r_is_wr) r_last_fill <= r_grant_d;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    fill_word   = '0;
    fill_we_i   = 1'b0;
    fill_we_d   = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    d_wr_done   = 1'b0;
    case (r_state)
      S_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_wr_addr;
        mem_data_in = r_wr_data;
      end
      S_FILL: begin
        mem_enable = r_issuing;
        if (r_issuing) mem_addr = r_base | {{(AWIDTH-4){1'b0}}, r_issue_cnt, 1'b0};
        if (w_ret_fire) begin
          fill_word = r_ret_cnt;
          fill_we_i = ~r_grant_d;
          fill_we_d = r_grant_d;
        end
      end
      S_DONE: begin
        d_wr_done = r_is_wr;
        i_done    = ~r_is_wr & ~r_grant_d;
        d_done    = ~r_is_wr & r_grant_d;
      end
      default: ;
    endcase
  end

  assign fill_data = mem_data_out;
  assign busy      = (r_state != S_IDLE);

endmodule
